// File: rtl/drbg_seq_pkg.sv
// Shared types and constants for the DRBG sequence-line extractor.
// Holds the FSM encoding, frame field widths and the CRC-8 polynomial.
// No logic here beyond a small majority-vote helper.
package drbg_seq_pkg;

    // FSM state encodings
    localparam logic [1:0] ENC_IDLE        = 2'd0;
    localparam logic [1:0] ENC_COUNT_LINES = 2'd1;
    localparam logic [1:0] ENC_SAMPLING    = 2'd2;
    localparam logic [1:0] ENC_CHECK       = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE        = ENC_IDLE,
        ST_COUNT_LINES = ENC_COUNT_LINES,
        ST_SAMPLING    = ENC_SAMPLING,
        ST_CHECK       = ENC_CHECK
    } state_t;

    // Frame layout on the sequence line, MSB first
    localparam int FRAME_BITS    = 48;
    localparam int PREAMBLE_BITS = 8;
    localparam int SEQ_BITS      = 32;
    localparam int CRC_BITS      = 8;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    // Width of the per-line sample index counter (saturating)
    localparam int SCNT_W = 16;

    // 2-of-3 majority vote
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/drbg_crc8_serial.sv
// Bit-serial CRC-8 (poly 0x07, MSB first, init 0) over the sequence field.
// Latency: result reflects a bit one cycle after en is asserted with it.
// No backpressure: consumes a bit on every cycle en is high; clear wins over en.
module drbg_crc8_serial
    import drbg_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;
    logic       fb;

    // Next CRC value: shift left, fold in polynomial when feedback is set
    always_comb begin
        crc_d = crc_q;
        fb    = crc_q[7] ^ din;
        if (clear) begin
            crc_d = 8'h00;
        end else if (en) begin
            crc_d = {crc_q[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
        end
    end

    // CRC register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/drbg_sequence_extractor.sv
// Finds the sequence line in vertical blanking, slices 48 bits, checks preamble/CRC-8.
// Latency: last bit decided at T, CHECK at T+1, outputs update at T+2.
// No backpressure: samples every sample_valid; DRBG_SEQ_EXTRACT_MAJORITY_EN selects 2-of-3 bit voting.
module drbg_sequence_extractor
    import drbg_seq_pkg::*;
#(
    parameter int         SEQ_LINE         = 14,
    parameter int         BIT_START_SAMPLE = 32,
    parameter int         SAMPLES_PER_BIT  = 8,
    parameter int         THRESHOLD        = 128,
    parameter logic [7:0] PREAMBLE         = 8'hA5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic        line_start,
    input  logic        sample_valid,
    input  logic [7:0]  luma,
    output logic [31:0] sequence_external,
    output logic        sequence_external_valid,
    output logic        crc_error,
    output logic        sync_error,
    output logic [15:0] error_count
);

    state_t                  state_q,    state_d;
    logic [9:0]              line_cnt_q, line_cnt_d;
    logic [SCNT_W-1:0]       samp_cnt_q, samp_cnt_d;
    logic [5:0]              bit_cnt_q,  bit_cnt_d;
    logic [FRAME_BITS-1:0]   shreg_q,    shreg_d;
    logic [SEQ_BITS-1:0]     seq_q,      seq_d;
    logic                    vld_q,      vld_d;
    logic                    crc_err_q,  crc_err_d;
    logic                    sync_err_q, sync_err_d;
    logic [15:0]             err_cnt_q,  err_cnt_d;
`ifdef DRBG_SEQ_EXTRACT_MAJORITY_EN
    logic                    s_m1_q,     s_m1_d;
    logic                    s_c_q,      s_c_d;
`endif

    logic              crc_clr;
    logic              crc_en;
    logic              crc_din;
    logic [7:0]        crc_val;
    logic              slice;
    logic              dec;
    logic              dec_bit;
    logic              samp_ok;
    logic [SCNT_W-1:0] centre_idx;

    // Sample index of the centre of the bit cell currently being collected
    assign centre_idx = SCNT_W'(BIT_START_SAMPLE + SAMPLES_PER_BIT / 2)
                      + SCNT_W'(bit_cnt_q) * SCNT_W'(SAMPLES_PER_BIT);
    assign slice   = (luma >= 8'(THRESHOLD));
    assign samp_ok = sample_valid && !line_start && !frame_start
                     && (state_q == ST_SAMPLING);

    drbg_crc8_serial u_crc (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (crc_clr),
        .en      (crc_en),
        .din     (crc_din),
        .crc     (crc_val)
    );

    // Next-state logic: counters, bit decisions, FSM transitions and result registers
    always_comb begin
        state_d    = state_q;
        line_cnt_d = line_cnt_q;
        samp_cnt_d = samp_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        seq_d      = seq_q;
        vld_d      = vld_q;
        crc_err_d  = 1'b0;
        sync_err_d = 1'b0;
        err_cnt_d  = err_cnt_q;
        crc_clr    = 1'b0;
        crc_en     = 1'b0;
        crc_din    = 1'b0;
        dec        = 1'b0;
        dec_bit    = 1'b0;

        // Sample index within the line; saturates so it never aliases a bit position
        if (line_start) begin
            samp_cnt_d = '0;
        end else if (sample_valid && (samp_cnt_q != '1)) begin
            samp_cnt_d = samp_cnt_q + SCNT_W'(1);
        end

`ifdef DRBG_SEQ_EXTRACT_MAJORITY_EN
        s_m1_d = s_m1_q;
        s_c_d  = s_c_q;
        if (samp_ok && (samp_cnt_q == centre_idx - SCNT_W'(1))) s_m1_d = slice;
        if (samp_ok && (samp_cnt_q == centre_idx))              s_c_d  = slice;
        dec     = samp_ok && (samp_cnt_q == centre_idx + SCNT_W'(1));
        dec_bit = maj3(s_m1_q, s_c_q, slice);
`else
        dec     = samp_ok && (samp_cnt_q == centre_idx);
        dec_bit = slice;
`endif

        if (frame_start) begin
            // Field start overrides everything, including a same-cycle line_start
            state_d    = ST_COUNT_LINES;
            line_cnt_d = 10'd0;
            vld_d      = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_COUNT_LINES: begin
                    if (line_start) begin
                        if (line_cnt_q == 10'(SEQ_LINE)) begin
                            state_d   = ST_SAMPLING;
                            bit_cnt_d = 6'd0;
                            crc_clr   = 1'b1;
                        end else if (line_cnt_q != 10'h3FF) begin
                            line_cnt_d = line_cnt_q + 10'd1;
                        end
                    end
                end
                ST_SAMPLING: begin
                    if (line_start) begin
                        // Line ended before all 48 bits arrived
                        sync_err_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else if (dec) begin
                        shreg_d = {shreg_q[FRAME_BITS-2:0], dec_bit};
                        crc_din = dec_bit;
                        crc_en  = (bit_cnt_q >= 6'(PREAMBLE_BITS))
                               && (bit_cnt_q <  6'(PREAMBLE_BITS + SEQ_BITS));
                        if (bit_cnt_q == 6'(FRAME_BITS - 1)) begin
                            state_d = ST_CHECK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 6'd1;
                        end
                    end
                end
                ST_CHECK: begin
                    state_d = ST_IDLE;
                    if (shreg_q[FRAME_BITS-1 -: PREAMBLE_BITS] != PREAMBLE) begin
                        sync_err_d = 1'b1;
                    end else if (crc_val != shreg_q[CRC_BITS-1:0]) begin
                        crc_err_d = 1'b1;
                    end else begin
                        seq_d = shreg_q[CRC_BITS +: SEQ_BITS];
                        vld_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // The two error sources come from different states, so at most one per cycle
        if ((crc_err_d || sync_err_d) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            line_cnt_q <= '0;
            samp_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            seq_q      <= '0;
            vld_q      <= 1'b0;
            crc_err_q  <= 1'b0;
            sync_err_q <= 1'b0;
            err_cnt_q  <= '0;
`ifdef DRBG_SEQ_EXTRACT_MAJORITY_EN
            s_m1_q     <= 1'b0;
            s_c_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            line_cnt_q <= line_cnt_d;
            samp_cnt_q <= samp_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            seq_q      <= seq_d;
            vld_q      <= vld_d;
            crc_err_q  <= crc_err_d;
            sync_err_q <= sync_err_d;
            err_cnt_q  <= err_cnt_d;
`ifdef DRBG_SEQ_EXTRACT_MAJORITY_EN
            s_m1_q     <= s_m1_d;
            s_c_q      <= s_c_d;
`endif
        end
    end

    assign sequence_external       = seq_q;
    assign sequence_external_valid = vld_q;
    assign crc_error               = crc_err_q;
    assign sync_error              = sync_err_q;
    assign error_count             = err_cnt_q;

endmodule

// File: tb/tb_drbg_sequence_extractor.sv
// Directed bench for drbg_sequence_extractor: builds sequence lines sample by sample
// and checks decode, latency, error pulses, error count, aborts and glitch handling.
// Expected CRC bytes are precomputed constants (poly 0x07, init 0).
module tb_drbg_sequence_extractor;

`ifdef DRBG_SEQ_EXTRACT_MAJORITY_EN
    localparam int LAST_IDX = 413;
`else
    localparam int LAST_IDX = 412;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        frame_start;
    logic        line_start;
    logic        sample_valid;
    logic [7:0]  luma;
    logic [31:0] sequence_external;
    logic        sequence_external_valid;
    logic        crc_error;
    logic        sync_error;
    logic [15:0] error_count;

    int checks      = 0;
    int failures    = 0;
    int crc_pulses  = 0;
    int sync_pulses = 0;

    always #5 clk = ~clk;

    drbg_sequence_extractor dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .frame_start             (frame_start),
        .line_start              (line_start),
        .sample_valid            (sample_valid),
        .luma                    (luma),
        .sequence_external       (sequence_external),
        .sequence_external_valid (sequence_external_valid),
        .crc_error               (crc_error),
        .sync_error              (sync_error),
        .error_count             (error_count)
    );

    // Count error pulses, sampled away from the active edge
    always @(negedge clk) begin
        if (crc_error === 1'b1)  crc_pulses++;
        if (sync_error === 1'b1) sync_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lum(input logic [47:0] frm, input logic [47:0] gl, input int i);
        int   k;
        int   p;
        logic b;
        if (i < 32 || i >= 32 + 48 * 8) return 8'd40;
        k = (i - 32) / 8;
        p = (i - 32) % 8;
        b = frm[47 - k];
        if (p == 4 && gl[47 - k]) b = ~b;
        return b ? 8'd128 : 8'd127;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_frame(input logic with_ls);
        frame_start = 1'b1;
        line_start  = with_ls;
        @(negedge clk);
        frame_start = 1'b0;
        line_start  = 1'b0;
    endtask

    task automatic send_line(input logic [47:0] frm, input logic [47:0] gl, input int last_idx);
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        for (int i = 0; i <= last_idx; i++) begin
            sample_valid = 1'b1;
            luma         = lum(frm, gl, i);
            @(negedge clk);
        end
        sample_valid = 1'b0;
        luma         = 8'd0;
    endtask

    // frame_start followed by lines 0..13, leaving the next line_start as line 14
    task automatic lead_in(input logic with_ls);
        pulse_frame(with_ls);
        repeat (14) send_line(48'h0, 48'h0, 10);
    endtask

    initial begin
        reset_n      = 1'b0;
        frame_start  = 1'b0;
        line_start   = 1'b0;
        sample_valid = 1'b0;
        luma         = 8'd0;
        idle(3);

        check("rst_seq",   sequence_external, 32'h0);
        check("rst_valid", {31'd0, sequence_external_valid}, 32'd0);
        check("rst_crc",   {31'd0, crc_error}, 32'd0);
        check("rst_sync",  {31'd0, sync_error}, 32'd0);
        check("rst_errcnt", {16'd0, error_count}, 32'd0);
        reset_n = 1'b1;
        idle(2);

        // Good field, sequence 0x00001234, CRC 0xF1; valid rises two cycles after last decision
        lead_in(1'b0);
        send_line({8'hA5, 32'h0000_1234, 8'hF1}, 48'h0, LAST_IDX);
        check("good1_valid_t1", {31'd0, sequence_external_valid}, 32'd0);
        @(negedge clk);
        check("good1_valid_t2", {31'd0, sequence_external_valid}, 32'd1);
        check("good1_seq", sequence_external, 32'h0000_1234);
        idle(3);
        check("good1_noerr", {16'd0, error_count}, 32'd0);

        // One CRC bit flipped
        lead_in(1'b0);
        check("crcbad_valid_cleared", {31'd0, sequence_external_valid}, 32'd0);
        send_line({8'hA5, 32'h0000_1234, 8'hF0}, 48'h0, LAST_IDX);
        idle(4);
        check("crcbad_pulses", crc_pulses, 32'd1);
        check("crcbad_valid", {31'd0, sequence_external_valid}, 32'd0);
        check("crcbad_seq_held", sequence_external, 32'h0000_1234);
        check("crcbad_errcnt", {16'd0, error_count}, 32'd1);

        // Preamble 0xA4
        lead_in(1'b0);
        send_line({8'hA4, 32'h0000_1234, 8'hF1}, 48'h0, LAST_IDX);
        idle(4);
        check("pre_sync_pulses", sync_pulses, 32'd1);
        check("pre_valid", {31'd0, sequence_external_valid}, 32'd0);
        check("pre_errcnt", {16'd0, error_count}, 32'd2);

        // Short line: line_start arrives just after bit 20 of the sequence line
        lead_in(1'b0);
        send_line({8'hA5, 32'h0000_1234, 8'hF1}, 48'h0, 200);
        send_line(48'h0, 48'h0, 3);
        idle(3);
        check("short_sync_pulses", sync_pulses, 32'd2);
        check("short_valid", {31'd0, sequence_external_valid}, 32'd0);
        check("short_errcnt", {16'd0, error_count}, 32'd3);

        // Next good field, opened with frame_start and line_start together
        lead_in(1'b1);
        send_line({8'hA5, 32'h0000_1234, 8'hF1}, 48'h0, LAST_IDX);
        idle(4);
        check("recover_valid", {31'd0, sequence_external_valid}, 32'd1);
        check("recover_seq", sequence_external, 32'h0000_1234);
        check("recover_sync_pulses", sync_pulses, 32'd2);

        // frame_start mid-sampling aborts silently; following field carries 0xDEADBEEF
        lead_in(1'b0);
        check("abort_valid_fall", {31'd0, sequence_external_valid}, 32'd0);
        send_line({8'hA5, 32'hDEAD_BEEF, 8'hCA}, 48'h0, 250);
        pulse_frame(1'b0);
        repeat (14) send_line(48'h0, 48'h0, 10);
        send_line({8'hA5, 32'hDEAD_BEEF, 8'hCA}, 48'h0, LAST_IDX);
        check("dead_valid_t1", {31'd0, sequence_external_valid}, 32'd0);
        @(negedge clk);
        check("dead_valid_t2", {31'd0, sequence_external_valid}, 32'd1);
        check("dead_seq", sequence_external, 32'hDEAD_BEEF);
        idle(3);
        check("dead_no_sync", sync_pulses, 32'd2);
        check("dead_no_crc", crc_pulses, 32'd1);
        check("dead_errcnt", {16'd0, error_count}, 32'd3);

        // Centre-sample glitch on every sequence bit of 0x55AA55AA (CRC 0x6F)
        lead_in(1'b0);
        send_line({8'hA5, 32'h55AA_55AA, 8'h6F}, {8'h00, 32'hFFFF_FFFF, 8'h00}, LAST_IDX);
        idle(4);
`ifdef DRBG_SEQ_EXTRACT_MAJORITY_EN
        check("glitch_valid", {31'd0, sequence_external_valid}, 32'd1);
        check("glitch_seq", sequence_external, 32'h55AA_55AA);
        check("glitch_crc_pulses", crc_pulses, 32'd1);
        check("glitch_errcnt", {16'd0, error_count}, 32'd3);
`else
        check("glitch_valid", {31'd0, sequence_external_valid}, 32'd0);
        check("glitch_seq", sequence_external, 32'hDEAD_BEEF);
        check("glitch_crc_pulses", crc_pulses, 32'd2);
        check("glitch_errcnt", {16'd0, error_count}, 32'd4);
`endif

        // Asynchronous reset in the middle of the sequence line
        lead_in(1'b0);
        send_line({8'hA5, 32'h0000_1234, 8'hF1}, 48'h0, 150);
        reset_n = 1'b0;
        #1;
        check("midrst_errcnt", {16'd0, error_count}, 32'd0);
        check("midrst_seq", sequence_external, 32'h0);
        idle(2);
        reset_n = 1'b1;
        idle(2);
        lead_in(1'b0);
        send_line({8'hA5, 32'h0000_1234, 8'hF1}, 48'h0, LAST_IDX);
        idle(3);
        check("midrst_resume_valid", {31'd0, sequence_external_valid}, 32'd1);
        check("midrst_resume_seq", sequence_external, 32'h0000_1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/drbg_sequence_extractor.md
Name: drbg_sequence_extractor

Overview:
- Upstream neighbour of the DRBG synchroniser on the descrambler side.
- Watches the decoded luma stream from the TVP5147M1 interface and locates the sequence line that the scrambler embeds in vertical blanking.
- Slices that line into bits, checks preamble and CRC-8, and presents the 32-bit external sequence number with a level-valid flag whose rising edge marks a fresh, checked value.

Parameters:
- SEQ_LINE, 14: index of the sequence line, counted in line_start pulses after frame_start; the first line_start after frame_start is line 0.
- BIT_START_SAMPLE, 32: sample index within the line of the first sample of bit cell 0.
- SAMPLES_PER_BIT, 8: samples per bit cell; must be at least 4 and even.
- THRESHOLD, 128: luma slicing level; a sample with luma >= THRESHOLD is a 1.
- PREAMBLE, 8'hA5: expected first 8 bits of the frame.

Ports:
- clk  in  1  pixel-domain clock.
- reset_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse at field start.
- line_start  in  1  one-cycle pulse at each active-line start.
- sample_valid  in  1  luma is a valid sample this cycle.
- luma  in  8  decoded luma sample.
- sequence_external  out  32  last good sequence number.
- sequence_external_valid  out  1  level flag: a good sequence was received this field.
- crc_error  out  1  one-cycle pulse on CRC mismatch.
- sync_error  out  1  one-cycle pulse on preamble mismatch or short line.
- error_count  out  16  saturating count of crc_error plus sync_error events.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- Bit frame on the line, MSB first, 48 bits: 8-bit preamble, 32-bit sequence, 8-bit CRC-8.
  - CRC-8: polynomial 0x07, init 0x00, computed over the 32 sequence bits only.
- Sample counter: cleared by line_start; increments on each sample_valid. The first sample_valid after line_start has index 0.
- Bit k is taken from the sample at index BIT_START_SAMPLE + k*SAMPLES_PER_BIT + SAMPLES_PER_BIT/2.
- States:
  - IDLE: on frame_start -> COUNT_LINES, with line counter = 0.
  - COUNT_LINES: each line_start increments the 10-bit line counter, saturating at 1023. The line_start that brings the count to SEQ_LINE enters SAMPLING, counting that line_start as line SEQ_LINE. Never reaching SEQ_LINE before the next frame_start is silent; stay in COUNT_LINES.
  - SAMPLING: shift each sliced bit into a 48-bit register. After bit 47 -> CHECK.
  - CHECK, 1 cycle:
    - Preamble mismatch: pulse sync_error, go to IDLE.
    - Preamble matches but CRC mismatches: pulse crc_error, go to IDLE.
    - Both match: register the 32-bit sequence and set valid, go to IDLE.
- Latency: last bit sampled at cycle T; CHECK at T+1; sequence_external and sequence_external_valid update at T+2.
- Valid rules:
  - sequence_external_valid is cleared on every frame_start, so a good field always produces a rising edge.
  - sequence_external holds its last good value across bad fields.
- frame_start in any state (including SAMPLING or CHECK): abort, clear valid, go to COUNT_LINES with the counter at 0. frame_start has priority over every other event in that cycle.
- line_start during SAMPLING: abort, pulse sync_error (short line), go to IDLE.
- frame_start and line_start in the same cycle: frame_start wins; the line_start is not counted.
- error_count increments by 1 per error pulse and saturates at 16'hFFFF.
- The sample counter saturates at its maximum; it never wraps into a false bit position.
- Asynchronous reset mid-field: all state cleared; extraction resumes at the next frame_start.

Optional Feature:
- Macro: DRBG_SEQ_EXTRACT_MAJORITY_EN.
- Defined: each bit is the 2-of-3 majority of the sliced samples at centre-1, centre and centre+1. Latency is unchanged, since the decision is made at centre+1 and the CHECK timing is taken from the last decision.
- Undefined: single centre sample, as above.

Decomposition:
- Package drbg_seq_pkg holds:
  - state encoding localparams;
  - FRAME_BITS = 48;
  - PREAMBLE_BITS = 8, SEQ_BITS = 32, CRC_BITS = 8;
  - CRC8_POLY = 8'h07.
- One sub-module, drbg_crc8_serial:
  - bit-serial CRC-8 with clear, enable and data-bit inputs;
  - enabled only for frame bits 8..39;
  - result compared in CHECK against bits 7..0.

Test Plan:
- Good field: PREAMBLE A5, sequence 0x0000_1234, correct CRC on line 14 -> sequence_external = 0x00001234, valid rises exactly 2 cycles after bit 47's sample.
- Same field with one CRC bit flipped -> crc_error pulses once, valid stays 0, sequence_external keeps its previous value, error_count = 1.
- Preamble 0xA4 -> sync_error pulse, no valid, error_count increments.
- line_start injected after bit 20 of the sequence line -> sync_error (short line), no valid; the next good field still decodes.
- frame_start during SAMPLING, then a good field with 0xDEADBEEF -> no error pulse for the aborted field, valid falls then rises, output = 0xDEADBEEF.
- With DRBG_SEQ_EXTRACT_MAJORITY_EN defined: a single-sample glitch at the centre of every bit of 0x55AA55AA -> still decodes correctly; without the macro the same stimulus gives crc_error.
